// File: rtl/dm_port_ctrl_if.sv
// Bus bundle between the loader/PE pipeline and the data-memory port controller.
// master: loader/PE side (and memory sink); slave: the controller.
interface dm_port_ctrl_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DM_ADDR_WIDTH = 8,
  parameter int unsigned INST_WIDTH    = 32
);
  logic                     ld_start;
  logic [DM_ADDR_WIDTH-1:0] ld_base;
  logic [DM_ADDR_WIDTH:0]   ld_len;
  logic                     ld_valid;
  logic [2*DATA_WIDTH-1:0]  ld_data;
  logic                     ld_ready;
  logic                     ld_busy;
  logic                     ld_done;

  logic                     pe_rd_valid;
  logic [DM_ADDR_WIDTH-1:0] pe_raddr0;
  logic [DM_ADDR_WIDTH-1:0] pe_raddr1;
  logic                     pe_rd_ready;
  logic                     pe_rvalid;

  logic                     pe_wb_valid;
  logic [DM_ADDR_WIDTH-1:0] pe_waddr;
  logic [2*DATA_WIDTH-1:0]  pe_wdata;
  logic                     pe_wb_ready;

  logic                     dm_wren;
  logic                     dm_rden;
  logic [INST_WIDTH-1:0]    dm_inst;
  logic [2*DATA_WIDTH-1:0]  dm_wdata;

  modport master (
    output ld_start, ld_base, ld_len, ld_valid, ld_data,
    output pe_rd_valid, pe_raddr0, pe_raddr1,
    output pe_wb_valid, pe_waddr, pe_wdata,
    input  ld_ready, ld_busy, ld_done, pe_rd_ready, pe_rvalid, pe_wb_ready,
    input  dm_wren, dm_rden, dm_inst, dm_wdata
  );

  modport slave (
    input  ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  pe_rd_valid, pe_raddr0, pe_raddr1,
    input  pe_wb_valid, pe_waddr, pe_wdata,
    output ld_ready, ld_busy, ld_done, pe_rd_ready, pe_rvalid, pe_wb_ready,
    output dm_wren, dm_rden, dm_inst, dm_wdata
  );
endinterface

// File: rtl/dm_port_ctrl.sv
// Data-memory port controller: burst loader FSM, round-robin write-port arbitration
// between loader and PE writeback, hazard-checked PE dual reads, instruction packing.
module dm_port_ctrl #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DM_ADDR_WIDTH = 8,
  parameter int unsigned INST_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst,
  dm_port_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                   state_q, state_d;
  logic [DM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DM_ADDR_WIDTH:0]   rem_q, rem_d;
  logic                     ld_prio_q, ld_prio_d;  // 1: loader wins the next contest
  logic                     rvalid_q;

  logic                     ld_req, pe_req, contest;
  logic                     ld_win, pe_win, grant;
  logic                     hazard, rd_ok;
  logic [DM_ADDR_WIDTH-1:0] waddr;
  logic [2*DATA_WIDTH-1:0]  wdata;

  // Everything memory-facing is qualified by rst so outputs read zero during reset.
  always_comb begin
    ld_req  = rst && (state_q == StLoad) && bus.ld_valid;
    pe_req  = rst && bus.pe_wb_valid;
    contest = ld_req && pe_req;
    ld_win  = ld_req && (!pe_req || ld_prio_q);
    pe_win  = pe_req && !ld_win;
    grant   = ld_win || pe_win;
    waddr   = '0;
    wdata   = '0;
    if (ld_win) begin
      waddr = ptr_q;
      wdata = bus.ld_data;
    end else if (pe_win) begin
      waddr = bus.pe_waddr;
      wdata = bus.pe_wdata;
    end
    // Memory is read-first: a read of the word being written waits one cycle.
    hazard = grant && ((bus.pe_raddr0 == waddr) || (bus.pe_raddr1 == waddr));
    rd_ok  = rst && bus.pe_rd_valid && !hazard;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      rem_q     <= '0;
      ld_prio_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      ld_prio_q <= ld_prio_d;
      rvalid_q  <= rd_ok;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    ld_prio_d = ld_prio_q;
    if (contest) ld_prio_d = pe_win;
    unique case (state_q)
      StIdle: begin
        if (bus.ld_start) begin
          if (bus.ld_len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            ptr_d   = bus.ld_base;
            rem_d   = bus.ld_len;
          end
        end
      end
      StLoad: begin
        if (ld_win) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (DM_ADDR_WIDTH+1)'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ld_ready    = ld_win;
    bus.pe_wb_ready = pe_win;
    bus.pe_rd_ready = rd_ok;
    bus.ld_busy     = rst && (state_q != StIdle);
    bus.ld_done     = rst && (state_q == StDone);
    bus.pe_rvalid   = rvalid_q;
    bus.dm_wren     = grant;
    bus.dm_rden     = rd_ok;
    bus.dm_wdata    = wdata;
    bus.dm_inst     = '0;
    bus.dm_inst[DM_ADDR_WIDTH-1:0]   = rd_ok ? bus.pe_raddr0 : '0;
    bus.dm_inst[8  +: DM_ADDR_WIDTH] = rd_ok ? bus.pe_raddr1 : '0;
    bus.dm_inst[16 +: DM_ADDR_WIDTH] = waddr;
  end
endmodule

// File: tb/tb_dm_port_ctrl.sv
// Bench for dm_port_ctrl: directed scenarios with literal expectations plus a long
// random run, all cross-checked each cycle against a behavioural model and memory.
module tb_dm_port_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dm_port_ctrl_if #(.DATA_WIDTH(DW), .DM_ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  dm_port_ctrl #(.DATA_WIDTH(DW), .DM_ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-first data memory with registered read data.
  logic [31:0] mem [256];
  logic [31:0] rdata0 = '0;
  logic [31:0] rdata1 = '0;
  always @(posedge clk) begin
    if (bus.dm_wren) mem[bus.dm_inst[23:16]] <= bus.dm_wdata;
    if (bus.dm_rden) begin
      rdata0 <= mem[bus.dm_inst[7:0]];
      rdata1 <= mem[bus.dm_inst[15:8]];
    end
  end

  // Behavioural model state.
  bit          m_loading = 0;
  bit          m_done    = 0;
  bit          m_pe_next = 1;
  bit          m_rvalid  = 0;
  logic [7:0]  m_ptr     = '0;
  int          m_rem     = 0;
  logic [31:0] m_mem [256];
  logic [31:0] m_r0 = '0;
  logic [31:0] m_r1 = '0;
  bit          ld_fire = 0;
  bit          wb_fire = 0;
  bit          rd_fire = 0;

  always @(negedge clk) begin : model_chk
    logic        ld_req, contest, ld_win, pe_win, grant, hazard, rd;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [71:0] act, exp;
    act = {bus.ld_ready, bus.ld_busy, bus.ld_done, bus.pe_rd_ready, bus.pe_rvalid,
           bus.pe_wb_ready, bus.dm_wren, bus.dm_rden, bus.dm_inst, bus.dm_wdata};
    if (!rst) begin
      chk("reset_outputs", 80'(act), 80'(0));
      m_loading = 0; m_done = 0; m_pe_next = 1; m_rvalid = 0; m_ptr = '0; m_rem = 0;
    end else begin
      ld_req  = m_loading && bus.ld_valid;
      contest = ld_req && bus.pe_wb_valid;
      ld_win  = ld_req && (!bus.pe_wb_valid || !m_pe_next);
      pe_win  = bus.pe_wb_valid && !ld_win;
      grant   = ld_win || pe_win;
      wa      = ld_win ? m_ptr : (pe_win ? bus.pe_waddr : 8'h00);
      wd      = ld_win ? bus.ld_data : (pe_win ? bus.pe_wdata : 32'h0);
      hazard  = grant && (bus.pe_raddr0 == wa || bus.pe_raddr1 == wa);
      rd      = bus.pe_rd_valid && !hazard;
      exp = {ld_win, m_loading || m_done, m_done, rd, m_rvalid, pe_win, grant, rd,
             8'h00, wa, rd ? bus.pe_raddr1 : 8'h00, rd ? bus.pe_raddr0 : 8'h00, wd};
      chk("outputs", 80'(act), 80'(exp));
      if (m_rvalid) chk("rdata", 80'({rdata0, rdata1}), 80'({m_r0, m_r1}));
      if (rd) begin
        m_r0 = m_mem[bus.pe_raddr0];
        m_r1 = m_mem[bus.pe_raddr1];
      end
      m_rvalid = rd;
      if (contest) m_pe_next = ld_win;
      if (pe_win) m_mem[bus.pe_waddr] = bus.pe_wdata;
      if (m_done) begin
        m_done = 0;
      end else if (m_loading) begin
        if (ld_win) begin
          m_mem[m_ptr] = bus.ld_data;
          m_ptr = m_ptr + 8'd1;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_loading = 0;
            m_done    = 1;
          end
        end
      end else if (bus.ld_start) begin
        if (bus.ld_len == 9'd0) m_done = 1;
        else begin
          m_loading = 1;
          m_ptr     = bus.ld_base;
          m_rem     = int'(bus.ld_len);
        end
      end
    end
    ld_fire = rst && bus.ld_valid && bus.ld_ready;
    wb_fire = rst && bus.pe_wb_valid && bus.pe_wb_ready;
    rd_fire = rst && bus.pe_rd_valid && bus.pe_rd_ready;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  // Counts accepted loader beats until ld_done, bounded; leaves time at a negedge.
  task automatic run_to_done(input string name, input int exp_beats, input int start_beats);
    int beats;
    bit seen;
    beats = start_beats;
    seen  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      neg;
      if (bus.ld_done) seen = 1;
      else begin
        if (bus.ld_ready) begin
          beats++;
          bus.ld_data = bus.ld_data + 32'd1;
        end
        cyc;
      end
    end
    chk({name, "_done_seen"}, 80'(seen), 80'(1));
    chk({name, "_beats"}, 80'(beats), 80'(exp_beats));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
    bus.ld_start = 0; bus.ld_base = '0; bus.ld_len = '0; bus.ld_valid = 0; bus.ld_data = '0;
    bus.pe_rd_valid = 0; bus.pe_raddr0 = '0; bus.pe_raddr1 = '0;
    bus.pe_wb_valid = 1; bus.pe_waddr = 8'h05; bus.pe_wdata = 32'h1234;
    bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'h07;
    neg;
    chk("in_reset", 80'({bus.dm_wren, bus.pe_wb_ready, bus.pe_rd_ready, bus.dm_rden,
                         bus.ld_busy, bus.ld_done, bus.pe_rvalid, bus.dm_inst}), 80'(0));
    cyc;
    rst = 1; bus.pe_wb_valid = 0; bus.pe_rd_valid = 0; bus.pe_raddr0 = '0;

    // Burst fill wrapping past the top of memory.
    cyc;
    bus.ld_start = 1; bus.ld_base = 8'hFE; bus.ld_len = 9'd4;
    neg;
    chk("start_no_beat", 80'({bus.ld_ready, bus.dm_wren}), 80'(0));
    cyc;
    bus.ld_start = 0; bus.ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_data = 32'(i + 1);
      neg;
      chk("fill_beat", 80'({bus.dm_wren, bus.ld_ready, bus.dm_inst[23:16], bus.dm_wdata}),
          80'({1'b1, 1'b1, 8'(8'hFE + i), 32'(i + 1)}));
      cyc;
    end
    bus.ld_valid = 0;
    neg;
    chk("fill_done", 80'({bus.ld_done, bus.ld_busy}), 80'(2'b11));
    cyc;
    neg;
    chk("fill_idle", 80'({bus.ld_done, bus.ld_busy}), 80'(0));
    cyc;
    bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'hFF; bus.pe_raddr1 = 8'h00;
    neg;
    chk("fill_rd_ready", 80'(bus.pe_rd_ready), 80'(1));
    cyc;
    bus.pe_rd_valid = 0;
    neg;
    chk("fill_read", 80'({bus.pe_rvalid, rdata0, rdata1}), 80'({1'b1, 32'd2, 32'd3}));

    // Write-port contest: PE wins first, then alternation.
    cyc;
    bus.ld_start = 1; bus.ld_base = 8'h40; bus.ld_len = 9'd8;
    cyc;
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 32'h1000;
    bus.pe_wb_valid = 1; bus.pe_waddr = 8'h80; bus.pe_wdata = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      neg;
      chk("contest", 80'({bus.dm_wren, bus.pe_wb_ready, bus.ld_ready}),
          80'({1'b1, i % 2 == 0, i % 2 == 1}));
      cyc;
      if (i % 2 == 1) bus.ld_data = bus.ld_data + 32'd1;
    end
    bus.pe_wb_valid = 0;
    run_to_done("contest", 8, 2);
    cyc;
    bus.ld_valid = 0;

    // Read-after-write hazard on the same address.
    cyc;
    bus.pe_wb_valid = 1; bus.pe_waddr = 8'h10; bus.pe_wdata = 32'hAAAA5555;
    bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'h10; bus.pe_raddr1 = 8'h11;
    neg;
    chk("raw_stall", 80'({bus.pe_wb_ready, bus.pe_rd_ready}), 80'(2'b10));
    cyc;
    bus.pe_wb_valid = 0;
    neg;
    chk("raw_accept", 80'(bus.pe_rd_ready), 80'(1));
    cyc;
    bus.pe_rd_valid = 0;
    neg;
    chk("raw_data", 80'({bus.pe_rvalid, rdata0}), 80'({1'b1, 32'hAAAA5555}));

    // Concurrent read and write to distinct addresses.
    cyc;
    bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'h20; bus.pe_raddr1 = 8'h21;
    bus.pe_wb_valid = 1; bus.pe_waddr = 8'h30; bus.pe_wdata = 32'h12345678;
    neg;
    chk("concurrent", 80'({bus.pe_rd_ready, bus.pe_wb_ready, bus.dm_inst[23:0]}),
        80'({1'b1, 1'b1, 24'h302120}));
    cyc;
    bus.pe_rd_valid = 0; bus.pe_wb_valid = 0;

    // Zero-length burst, then ld_start ignored while loading.
    bus.ld_start = 1; bus.ld_base = 8'h33; bus.ld_len = 9'd0;
    neg;
    chk("zero_start", 80'({bus.ld_done, bus.ld_busy, bus.dm_wren}), 80'(0));
    cyc;
    bus.ld_start = 0;
    neg;
    chk("zero_done", 80'({bus.ld_done, bus.ld_busy, bus.dm_wren}), 80'(3'b110));
    cyc;
    neg;
    chk("zero_idle", 80'(bus.ld_busy), 80'(0));
    cyc;
    bus.ld_start = 1; bus.ld_base = 8'h90; bus.ld_len = 9'd3;
    cyc;
    bus.ld_base = 8'h00; bus.ld_len = 9'd9; bus.ld_valid = 1; bus.ld_data = 32'd77;
    neg;
    chk("ignore_ptr", 80'({bus.ld_ready, bus.dm_inst[23:16]}), 80'({1'b1, 8'h90}));
    cyc;
    bus.ld_start = 0; bus.ld_data = 32'd78;
    run_to_done("ignore", 3, 1);
    cyc;
    bus.ld_valid = 0;

    // Reset in the middle of a burst.
    bus.ld_start = 1; bus.ld_base = 8'h50; bus.ld_len = 9'd5;
    cyc;
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 32'hC0DE0001;
    cyc;
    bus.ld_data = 32'hC0DE0002;
    cyc;
    rst = 0; bus.pe_wb_valid = 1; bus.pe_waddr = 8'h03; bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'h50;
    #1;
    chk("rst_outputs", 80'({bus.ld_ready, bus.ld_busy, bus.ld_done, bus.pe_rd_ready,
                            bus.pe_rvalid, bus.pe_wb_ready, bus.dm_wren, bus.dm_rden,
                            bus.dm_inst, bus.dm_wdata}), 80'(0));
    cyc;
    rst = 1; bus.pe_wb_valid = 0; bus.pe_rd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      neg;
      chk("rst_no_done", 80'({bus.ld_done, bus.ld_busy, bus.ld_ready}), 80'(0));
      cyc;
    end
    bus.ld_valid = 0; bus.pe_rd_valid = 1; bus.pe_raddr0 = 8'h50; bus.pe_raddr1 = 8'h51;
    cyc;
    bus.pe_rd_valid = 0;
    neg;
    chk("rst_mem_kept", 80'({rdata0, rdata1}), 80'({32'hC0DE0001, 32'hC0DE0002}));

    // Random traffic; requesters hold their request until it is accepted.
    for (int c = 0; c < 5000; c++) begin
      cyc;
      if (!rst) rst = 1;
      else if ($urandom_range(0, 599) == 0) rst = 0;
      bus.ld_start = ($urandom_range(0, 7) == 0);
      bus.ld_base  = 8'($urandom);
      case ($urandom_range(0, 15))
        0:       bus.ld_len = 9'd0;
        1:       bus.ld_len = 9'd256;
        default: bus.ld_len = 9'($urandom_range(1, 6));
      endcase
      if (!bus.ld_valid || ld_fire) begin
        bus.ld_valid = ($urandom_range(0, 3) != 0);
        bus.ld_data  = $urandom;
      end
      if (!bus.pe_wb_valid || wb_fire) begin
        bus.pe_wb_valid = ($urandom_range(0, 1) == 0);
        bus.pe_waddr    = 8'($urandom_range(0, 15));
        bus.pe_wdata    = $urandom;
      end
      if (!bus.pe_rd_valid || rd_fire) begin
        bus.pe_rd_valid = ($urandom_range(0, 1) == 0);
        bus.pe_raddr0   = 8'($urandom_range(0, 15));
        bus.pe_raddr1   = 8'($urandom_range(0, 15));
      end
    end
    cyc;
    rst = 1; bus.ld_start = 0; bus.ld_valid = 0; bus.pe_wb_valid = 0; bus.pe_rd_valid = 0;
    neg;
    neg;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
